// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue
// Instruction-fetch front end: owns the fetch PC, drives a synchronous
// instruction ROM, and buffers {pc, inst} pairs in a DEPTH-entry FIFO that
// decode drains under a stall/valid handshake. A redirect flushes the queue
// and any in-flight fetch, then restarts fetch at the new PC.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   rom_ce_o        ROM request this cycle
//   rom_addr_o      ROM address (current fetch PC)
//   rom_data_i      ROM data, valid the cycle after a request
//   redirect_i      flush and restart fetch at redirect_pc_i
//   redirect_pc_i   new fetch PC
//   stall_i         decode cannot accept the head this cycle
//   id_valid_o      queue head valid
//   id_pc_o         head PC (0 when empty)
//   id_inst_o       head instruction (0 when empty)
//   count_o         occupied queue entries

module inst_fetch_queue #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       PC_STEP  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     rom_ce_o,
    output logic [ADDR_W-1:0]        rom_addr_o,
    input  logic [DATA_W-1:0]        rom_data_i,
    input  logic                     redirect_i,
    input  logic [ADDR_W-1:0]        redirect_pc_i,
    input  logic                     stall_i,
    output logic                     id_valid_o,
    output logic [ADDR_W-1:0]        id_pc_o,
    output logic [DATA_W-1:0]        id_inst_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    // Architectural state
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] req_pc_q,   req_pc_d;
    logic              inflight_q, inflight_d;
    logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
    logic [CNT_W-1:0]  count_q,    count_d;

    // Queue storage; contents are don't-care outside the occupied window
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [DATA_W-1:0] inst_mem [DEPTH];

    logic [OCC_W-1:0]  occupancy;
    logic              issue;
    logic              push;
    logic              pop;
    logic              head_valid;

    // Handshake decode. The credit check counts the outstanding request as
    // occupied and deliberately ignores a same-cycle pop.
    always_comb begin
        occupancy  = OCC_W'(count_q) + OCC_W'(inflight_q);
        head_valid = (count_q != '0);
        issue      = !rst && !redirect_i && (occupancy < OCC_W'(DEPTH));
        push       = inflight_q && !redirect_i;
        pop        = head_valid && !stall_i && !redirect_i;
    end

    // Next-state logic; redirect outranks issue, push and pop
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = 1'b0;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        if (redirect_i) begin
            // The response landing this cycle belongs to the old path: drop it
            fetch_pc_d = redirect_pc_i;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
                req_pc_d   = fetch_pc_q;
                inflight_d = 1'b1;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Queue write port; pairs the returning word with the PC that requested it
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= req_pc_q;
            inst_mem[wr_ptr_q] <= rom_data_i;
        end
    end

    // Outputs: ROM side straight from the fetch PC, decode side from the head
    always_comb begin
        rom_ce_o   = issue;
        rom_addr_o = fetch_pc_q;
        id_valid_o = head_valid;
        id_pc_o    = head_valid ? pc_mem[rd_ptr_q]   : '0;
        id_inst_o  = head_valid ? inst_mem[rd_ptr_q] : '0;
        count_o    = count_q;
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rst_w = 1'b0;
    logic        stall = 1'b1;
    logic        stall_w = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;

    logic        rom_ce, rom_ce_w;
    logic [31:0] rom_addr, rom_addr_w;
    logic [31:0] rom_data = '0, rom_data_w = '0;
    logic        id_valid, id_valid_w;
    logic [31:0] id_pc, id_pc_w, id_inst, id_inst_w;
    logic [2:0]  count, count_w;

    exp_t exp_q[$];
    exp_t exp_w[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   pops = 0, pops_w = 0;
    int   total = 0, total_w = 0;

    always #5 clk = ~clk;

    inst_fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(4),
                       .RESET_PC(32'h0000_0000), .PC_STEP(4)) u_dut (
        .clk(clk), .rst(rst),
        .rom_ce_o(rom_ce), .rom_addr_o(rom_addr), .rom_data_i(rom_data),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc), .stall_i(stall),
        .id_valid_o(id_valid), .id_pc_o(id_pc), .id_inst_o(id_inst),
        .count_o(count)
    );

    inst_fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(4),
                       .RESET_PC(32'hFFFF_FFF8), .PC_STEP(4)) u_wrap (
        .clk(clk), .rst(rst_w),
        .rom_ce_o(rom_ce_w), .rom_addr_o(rom_addr_w), .rom_data_i(rom_data_w),
        .redirect_i(1'b0), .redirect_pc_i(32'h0), .stall_i(stall_w),
        .id_valid_o(id_valid_w), .id_pc_o(id_pc_w), .id_inst_o(id_inst_w),
        .count_o(count_w)
    );

    // Synchronous ROMs: word = {16'hC0DE, addr[15:0]}
    always @(posedge clk) begin
        if (rom_ce)   rom_data   <= {16'hC0DE, rom_addr[15:0]};
        if (rom_ce_w) rom_data_w <= {16'hC0DE, rom_addr_w[15:0]};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitors: every consumed head is compared against the scoreboard
    always @(negedge clk) begin
        if (id_valid && !stall && !redirect) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL main_unexpected_pop: got pc 0x%08h expected none", id_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("main_pc", id_pc, e.pc);
                chk("main_inst", id_inst, e.inst);
            end
            pops++;
        end
        if (id_valid_w && !stall_w) begin
            if (exp_w.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL wrap_unexpected_pop: got pc 0x%08h expected none", id_pc_w);
            end else begin
                exp_t e;
                e = exp_w.pop_front();
                chk("wrap_pc", id_pc_w, e.pc);
                chk("wrap_inst", id_inst_w, e.inst);
            end
            pops_w++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input bit w, input logic [31:0] pc, input logic [31:0] inst);
        exp_t e;
        e.pc   = pc;
        e.inst = inst;
        if (w) begin
            exp_w.push_back(e);
            total_w++;
        end else begin
            exp_q.push_back(e);
            total++;
        end
    endtask

    // Advance at least one cycle, until the pop count reaches target or budget runs out
    task automatic wait_pops(input bit w, input int target, input int budget, input string name);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (((w ? pops_w : pops) < target) && n < budget);
        chk(name, 32'(w ? pops_w : pops), 32'(target));
    endtask

    logic [31:0] wrap_pc   [14];
    logic [31:0] wrap_inst [14];

    initial begin
        wrap_pc = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004,
                    32'h0000_0008, 32'h0000_000C, 32'h0000_0010, 32'h0000_0014,
                    32'h0000_0018, 32'h0000_001C, 32'h0000_0020, 32'h0000_0024,
                    32'h0000_0028, 32'h0000_002C};
        wrap_inst = '{32'hC0DE_FFF8, 32'hC0DE_FFFC, 32'hC0DE_0000, 32'hC0DE_0004,
                      32'hC0DE_0008, 32'hC0DE_000C, 32'hC0DE_0010, 32'hC0DE_0014,
                      32'hC0DE_0018, 32'hC0DE_001C, 32'hC0DE_0020, 32'hC0DE_0024,
                      32'hC0DE_0028, 32'hC0DE_002C};

        // Reset values
        #1;
        rst   = 1'b1;
        rst_w = 1'b1;
        stall = 1'b0;
        step();
        step();
        chk("rst_ce", 32'(rom_ce), 32'h0);
        chk("rst_addr", rom_addr, 32'h0);
        chk("rst_valid", 32'(id_valid), 32'h0);
        chk("rst_pc", id_pc, 32'h0);
        chk("rst_inst", id_inst, 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_addr_wrap", rom_addr_w, 32'hFFFF_FFF8);

        // Streaming from reset release with stall low
        push_exp(0, 32'h0, 32'hC0DE_0000);
        push_exp(0, 32'h4, 32'hC0DE_0004);
        push_exp(0, 32'h8, 32'hC0DE_0008);
        rst = 1'b0;
        @(negedge clk);
        chk("stream_ce0", 32'(rom_ce), 32'h1);
        chk("stream_addr0", rom_addr, 32'h0);
        step();
        @(negedge clk);
        chk("stream_ce1", 32'(rom_ce), 32'h1);
        chk("stream_addr1", rom_addr, 32'h4);
        step();
        @(negedge clk);
        chk("stream_addr2", rom_addr, 32'h8);
        wait_pops(0, total, 20, "stream_drain");
        stall = 1'b1;

        // Fill with stall held: exactly four requests, then back-pressure
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("fill_ce", 32'(rom_ce), 32'h1);
            chk("fill_addr", rom_addr, 32'(4 * i));
            step();
        end
        @(negedge clk);
        chk("fill_ce_off", 32'(rom_ce), 32'h0);
        step();
        @(negedge clk);
        chk("fill_ce_full", 32'(rom_ce), 32'h0);
        chk("fill_count", 32'(count), 32'h4);
        chk("fill_head", id_pc, 32'h0);
        push_exp(0, 32'h0,  32'hC0DE_0000);
        push_exp(0, 32'h4,  32'hC0DE_0004);
        push_exp(0, 32'h8,  32'hC0DE_0008);
        push_exp(0, 32'hC,  32'hC0DE_000C);
        push_exp(0, 32'h10, 32'hC0DE_0010);
        step();
        stall = 1'b0;
        @(negedge clk);
        chk("drain_ce_full", 32'(rom_ce), 32'h0);
        step();
        @(negedge clk);
        chk("resume_ce", 32'(rom_ce), 32'h1);
        chk("resume_addr", rom_addr, 32'h10);
        wait_pops(0, total, 20, "fill_drain");
        stall = 1'b1;

        // Redirect with two queued and one in flight
        chk("pre_redirect_count", 32'(count), 32'h2);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        @(negedge clk);
        chk("redirect_ce", 32'(rom_ce), 32'h0);
        step();
        redirect = 1'b0;
        @(negedge clk);
        chk("post_redirect_count", 32'(count), 32'h0);
        chk("post_redirect_valid", 32'(id_valid), 32'h0);
        chk("post_redirect_addr", rom_addr, 32'h100);
        chk("post_redirect_ce", 32'(rom_ce), 32'h1);
        push_exp(0, 32'h100, 32'hC0DE_0100);
        push_exp(0, 32'h104, 32'hC0DE_0104);
        step();
        stall = 1'b0;
        wait_pops(0, total, 20, "redirect_drain");
        stall = 1'b1;

        // Redirect while the head would otherwise be consumed
        step();
        step();
        chk("pop_redirect_head_valid", 32'(id_valid), 32'h1);
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        stall       = 1'b0;
        step();
        redirect = 1'b0;
        stall    = 1'b1;
        @(negedge clk);
        chk("pop_redirect_count", 32'(count), 32'h0);
        chk("pop_redirect_addr", rom_addr, 32'h200);
        push_exp(0, 32'h200, 32'hC0DE_0200);
        push_exp(0, 32'h204, 32'hC0DE_0204);
        step();
        stall = 1'b0;
        wait_pops(0, total, 20, "pop_redirect_drain");
        stall = 1'b1;

        // Asynchronous reset between edges at count 3
        begin
            int n;
            n = 0;
            while (count != 3'd3 && n < 10) begin
                step();
                n++;
            end
            chk("async_pre_count", 32'(count), 32'h3);
        end
        #3;
        rst = 1'b1;
        #1;
        chk("async_ce", 32'(rom_ce), 32'h0);
        chk("async_addr", rom_addr, 32'h0);
        chk("async_valid", 32'(id_valid), 32'h0);
        chk("async_pc", id_pc, 32'h0);
        chk("async_inst", id_inst, 32'h0);
        chk("async_count", 32'(count), 32'h0);
        step();
        step();
        push_exp(0, 32'h0, 32'hC0DE_0000);
        push_exp(0, 32'h4, 32'hC0DE_0004);
        rst   = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        chk("async_restart_addr", rom_addr, 32'h0);
        chk("async_restart_ce", 32'(rom_ce), 32'h1);
        wait_pops(0, total, 20, "async_drain");
        stall = 1'b1;

        // Address wrap and pointer wrap over 14 pushes
        for (int i = 0; i < 14; i++) push_exp(1, wrap_pc[i], wrap_inst[i]);
        rst_w   = 1'b0;
        stall_w = 1'b0;
        @(negedge clk);
        chk("wrap_addr0", rom_addr_w, 32'hFFFF_FFF8);
        step();
        @(negedge clk);
        chk("wrap_addr1", rom_addr_w, 32'hFFFF_FFFC);
        step();
        @(negedge clk);
        chk("wrap_addr2", rom_addr_w, 32'h0000_0000);
        wait_pops(1, 5, 30, "wrap_mid");
        stall_w = 1'b1;
        step();
        step();
        step();
        stall_w = 1'b0;
        wait_pops(1, total_w, 60, "wrap_drain");
        stall_w = 1'b1;
        step();

        chk("main_scoreboard_empty", 32'(exp_q.size()), 32'h0);
        chk("wrap_scoreboard_empty", 32'(exp_w.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
